// File: rtl/mvau_weight_streamer.sv
// Weight-memory sequencer for the MVAU: sweeps the weight memory NUM_PASSES times
// and streams the registered read data out over AXI-Stream through a 2-entry skid FIFO.
module mvau_weight_streamer #(
   parameter int SIMD         = 2,
   parameter int TW           = 1,
   parameter int WMEM_DEPTH   = 4,
   parameter int WMEM_ADDR_BW = 4,
   parameter int NUM_PASSES   = 4
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [WMEM_ADDR_BW-1:0] wmem_addr,
   input  logic [SIMD*TW-1:0]      wmem_out,
   output logic [SIMD*TW-1:0]      m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast
);

   localparam int DW      = SIMD * TW;
   localparam int PASS_BW = $clog2(NUM_PASSES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
   logic [PASS_BW-1:0]      pass_q, pass_d;
   logic                    inflight_q, inflight_last_q;
   logic [1:0]              occ_q, occ_d;
   logic [DW-1:0]           data0_q, data0_d, data1_q, data1_d;
   logic                    last0_q, last0_d, last1_q, last1_d;

   logic       issue, pop, push, addr_at_end, final_issue;
   logic [2:0] level;

   assign m_axis_tvalid = (occ_q != 2'd0);
   assign m_axis_tdata  = data0_q;
   assign m_axis_tlast  = last0_q;
   assign wmem_addr     = addr_q;

   assign pop         = m_axis_tvalid && m_axis_tready;
   assign push        = inflight_q;
   // Projected FIFO level next cycle, counting the read already in flight.
   assign level       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign addr_at_end = (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
   assign final_issue = issue && addr_at_end && (pass_q == PASS_BW'(NUM_PASSES - 1));

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)       state_d = RUN;
         RUN:     if (final_issue) state_d = DRAIN;
         DRAIN:   if (done)        state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != IDLE);
      done  = (state_q == DRAIN) && (occ_q == 2'd0) && !inflight_q;
      issue = (state_q == RUN) && (level < 3'd2);
   end

   always_comb begin
      addr_d = addr_q;
      pass_d = pass_q;
      if (state_q == IDLE && start) begin
         addr_d = '0;
         pass_d = '0;
      end else if (issue) begin
         if (addr_at_end) begin
            addr_d = '0;
            pass_d = pass_q + PASS_BW'(1);
         end else begin
            addr_d = addr_q + WMEM_ADDR_BW'(1);
         end
      end
   end

   // Skid FIFO: entry 0 is the head; push without pop while full cannot happen.
   always_comb begin
      occ_d   = occ_q;
      data0_d = data0_q;
      data1_d = data1_q;
      last0_d = last0_q;
      last1_d = last1_q;
      case (occ_q)
         2'd0: begin
            if (push) begin
               data0_d = wmem_out;
               last0_d = inflight_last_q;
               occ_d   = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               data0_d = wmem_out;
               last0_d = inflight_last_q;
            end else if (push) begin
               data1_d = wmem_out;
               last1_d = inflight_last_q;
               occ_d   = 2'd2;
            end else if (pop) begin
               occ_d   = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               data0_d = data1_q;
               last0_d = last1_q;
               if (push) begin
                  data1_d = wmem_out;
                  last1_d = inflight_last_q;
               end else begin
                  occ_d   = 2'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         addr_q          <= '0;
         pass_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         occ_q           <= 2'd0;
         data0_q         <= '0;
         data1_q         <= '0;
         last0_q         <= 1'b0;
         last1_q         <= 1'b0;
      end else begin
         addr_q          <= addr_d;
         pass_q          <= pass_d;
         inflight_q      <= issue;
         inflight_last_q <= issue && addr_at_end;
         occ_q           <= occ_d;
         data0_q         <= data0_d;
         data1_q         <= data1_d;
         last0_q         <= last0_d;
         last1_q         <= last1_d;
      end
   end

endmodule

// File: tb/tb_mvau_weight_streamer.sv
// Scoreboard bench for mvau_weight_streamer: a 4x3 sweep instance and a 1x2 sweep
// instance, each fed by a registered weight-memory model.
module tb_mvau_weight_streamer;

   localparam int D0 = 4;
   localparam int P0 = 3;
   localparam int D1 = 1;
   localparam int P1 = 2;

   logic       aclk;
   logic       areset;
   logic       start0, start1;
   logic       busy0, busy1, done0, done1;
   logic [3:0] addr0, addr1;
   logic [7:0] wmemOut0, wmemOut1;
   logic [7:0] tdata0, tdata1;
   logic       tvalid0, tvalid1, tready0, tready1, tlast0, tlast1;

   logic [7:0] mem0 [16];
   logic [7:0] mem1Word;

   logic [8:0] expQ0[$];
   logic [8:0] expQ1[$];
   logic [8:0] e0, e1;
   bit         doneExpect0, doneExpect1;
   int         beatCount0, beatCount1;

   int checks;
   int errors;

   bit   randReady;
   logic readyLevel;

   mvau_weight_streamer #(
      .SIMD(2), .TW(4), .WMEM_DEPTH(D0), .WMEM_ADDR_BW(4), .NUM_PASSES(P0)
   ) dut0 (
      .aclk(aclk), .areset(areset), .start(start0), .busy(busy0), .done(done0),
      .wmem_addr(addr0), .wmem_out(wmemOut0), .m_axis_tdata(tdata0),
      .m_axis_tvalid(tvalid0), .m_axis_tready(tready0), .m_axis_tlast(tlast0)
   );

   mvau_weight_streamer #(
      .SIMD(2), .TW(4), .WMEM_DEPTH(D1), .WMEM_ADDR_BW(4), .NUM_PASSES(P1)
   ) dut1 (
      .aclk(aclk), .areset(areset), .start(start1), .busy(busy1), .done(done1),
      .wmem_addr(addr1), .wmem_out(wmemOut1), .m_axis_tdata(tdata1),
      .m_axis_tvalid(tvalid1), .m_axis_tready(tready1), .m_axis_tlast(tlast1)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Weight memories with one cycle of read latency.
   always @(posedge aclk) begin
      wmemOut0 <= mem0[addr0];
      wmemOut1 <= mem1Word;
   end

   // Ready driver changes mid-cycle so the monitors see a settled value at negedge.
   initial begin
      tready0 = 1'b1;
      tready1 = 1'b1;
      forever begin
         @(posedge aclk);
         #2;
         tready0 = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor for the 4x3 instance: pops expectations on every accepted beat.
   always @(negedge aclk) begin
      if (!areset) begin
         if (doneExpect0) begin
            checkOutput("dut0_done_pulse", done0, 1);
            doneExpect0 = 1'b0;
         end else begin
            checkOutput("dut0_no_done", done0, 0);
         end
         if (tvalid0 && tready0) begin
            if (expQ0.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL dut0_extra_beat: got data %0h, expected no beat", tdata0);
            end else begin
               e0 = expQ0.pop_front();
               checkOutput("dut0_tdata", tdata0, e0[7:0]);
               checkOutput("dut0_tlast", tlast0, e0[8]);
               beatCount0++;
               if (expQ0.size() == 0) doneExpect0 = 1'b1;
            end
         end
      end
   end

   // Monitor for the 1x2 instance.
   always @(negedge aclk) begin
      if (!areset) begin
         if (doneExpect1) begin
            checkOutput("dut1_done_pulse", done1, 1);
            doneExpect1 = 1'b0;
         end else begin
            checkOutput("dut1_no_done", done1, 0);
         end
         if (tvalid1 && tready1) begin
            if (expQ1.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL dut1_extra_beat: got data %0h, expected no beat", tdata1);
            end else begin
               e1 = expQ1.pop_front();
               checkOutput("dut1_tdata", tdata1, e1[7:0]);
               checkOutput("dut1_tlast", tlast1, e1[8]);
               beatCount1++;
               if (expQ1.size() == 0) doneExpect1 = 1'b1;
            end
         end
      end
   end

   // Pulses start and loads the reference sequence: every address in order, once per pass.
   task automatic applyStimulus(input int which);
      logic [8:0] e;
      @(posedge aclk);
      #1;
      if (which == 0) begin
         for (int p = 0; p < P0; p++)
            for (int a = 0; a < D0; a++) begin
               e = {a == D0 - 1, mem0[a]};
               expQ0.push_back(e);
            end
         start0 = 1'b1;
      end else begin
         for (int p = 0; p < P1; p++) begin
            e = {1'b1, mem1Word};
            expQ1.push_back(e);
         end
         start1 = 1'b1;
      end
      @(posedge aclk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic waitDone(input int which, input int limit, output int n);
      bit found;
      found = 1'b0;
      n = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge aclk);
         #1;
         n++;
         if ((which == 0) ? done0 : done1) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: no done from dut%0d within %0d cycles", which, limit);
      end
      @(negedge aclk);
      #1;
      if (which == 0) begin
         checkOutput("dut0_busy_after_done", busy0, 0);
         checkOutput("dut0_queue_drained", expQ0.size(), 0);
      end else begin
         checkOutput("dut1_busy_after_done", busy1, 0);
         checkOutput("dut1_queue_drained", expQ1.size(), 0);
      end
   endtask

   task automatic loadDefaultMem();
      foreach (mem0[i]) mem0[i] = 8'h00;
      mem0[0] = 8'h10;
      mem0[1] = 8'h21;
      mem0[2] = 8'h32;
      mem0[3] = 8'h43;
   endtask

   initial begin
      int n;
      int base;
      bit reached;
      checks = 0;
      errors = 0;
      areset = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      randReady = 1'b0;
      readyLevel = 1'b1;
      doneExpect0 = 1'b0;
      doneExpect1 = 1'b0;
      beatCount0 = 0;
      beatCount1 = 0;
      mem1Word = 8'h5A;
      loadDefaultMem();

      @(posedge aclk);
      #1;
      checkOutput("reset_tvalid", tvalid0, 0);
      checkOutput("reset_tdata", tdata0, 0);
      checkOutput("reset_tlast", tlast0, 0);
      checkOutput("reset_addr", addr0, 0);
      checkOutput("reset_busy", busy0, 0);
      checkOutput("reset_done", done0, 0);
      @(posedge aclk);
      #3;
      areset = 1'b0;

      $display("[TB] full-rate sweep");
      base = beatCount0;
      applyStimulus(0);
      @(negedge aclk);
      #1;
      checkOutput("busy_after_start", busy0, 1);
      checkOutput("tvalid_c1", tvalid0, 0);
      @(negedge aclk);
      #1;
      checkOutput("tvalid_c2", tvalid0, 0);
      @(negedge aclk);
      #1;
      checkOutput("tvalid_c3", tvalid0, 1);
      waitDone(0, 100, n);
      checkOutput("done_latency", n, 12);
      checkOutput("beats_full_rate", beatCount0 - base, 12);

      $display("[TB] backpressure");
      base = beatCount0;
      applyStimulus(0);
      @(posedge aclk);
      #1;
      @(posedge aclk);
      #1;
      readyLevel = 1'b0;
      repeat (7) @(posedge aclk);
      @(negedge aclk);
      #1;
      checkOutput("bp_tvalid", tvalid0, 1);
      checkOutput("bp_tdata", tdata0, 8'h10);
      checkOutput("bp_addr", addr0, 2);
      @(posedge aclk);
      #1;
      readyLevel = 1'b1;
      waitDone(0, 100, n);
      checkOutput("beats_backpressure", beatCount0 - base, 12);

      $display("[TB] random ready, random weights");
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < D0; a++) mem0[a] = 8'($urandom);
         randReady = 1'b1;
         base = beatCount0;
         applyStimulus(0);
         waitDone(0, 300, n);
         checkOutput("beats_random", beatCount0 - base, 12);
      end
      randReady = 1'b0;
      loadDefaultMem();

      $display("[TB] start during sweep");
      base = beatCount0;
      applyStimulus(0);
      repeat (5) @(posedge aclk);
      #1;
      start0 = 1'b1;
      @(posedge aclk);
      #1;
      start0 = 1'b0;
      waitDone(0, 100, n);
      checkOutput("beats_second_start", beatCount0 - base, 12);
      repeat (4) @(posedge aclk);

      $display("[TB] reset mid-sweep");
      base = beatCount0;
      applyStimulus(0);
      reached = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge aclk);
         #1;
         if (beatCount0 - base >= 6) begin
            reached = 1'b1;
            break;
         end
      end
      if (!reached) begin
         checks++;
         errors++;
         $display("[TB] FAIL beat6_timeout: only %0d beats seen, expected 6", beatCount0 - base);
      end
      @(posedge aclk);
      #3;
      checkOutput("pre_reset_tvalid", tvalid0, 1);
      areset = 1'b1;
      expQ0.delete();
      doneExpect0 = 1'b0;
      #1;
      checkOutput("async_reset_tvalid", tvalid0, 0);
      checkOutput("async_reset_addr", addr0, 0);
      checkOutput("async_reset_busy", busy0, 0);
      repeat (2) @(posedge aclk);
      #3;
      areset = 1'b0;
      base = beatCount0;
      applyStimulus(0);
      waitDone(0, 100, n);
      checkOutput("beats_after_reset", beatCount0 - base, 12);

      $display("[TB] single-word memory");
      mem1Word = 8'($urandom);
      base = beatCount1;
      applyStimulus(1);
      waitDone(1, 50, n);
      checkOutput("beats_depth1", beatCount1 - base, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
